bus_snoop: RTL and testbench



---
 rtl/bus_snoop.sv | 148 ++++++++++++++
 tb/tb_bus_snoop.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_snoop.sv
// bus_snoop: receive side of the inter-cache coherence bus.
// Captures one message per sender handshake and drops reads, invalid frames
// and the local cache's own traffic. Writes from other caches are queued as
// invalidations in a small circular FIFO. The local set array drains that
// FIFO over a valid/ready interface.
module bus_snoop #(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [1:0] ID         = 2'd2,
    parameter int         DEPTH      = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH+4:0] bus_rx,
    input  logic                  bus_rx_valid,
    output logic                  bus_rx_ack,
    output logic                  inv_valid,
    output logic [ADDR_WIDTH-1:0] inv_addr,
    input  logic                  inv_ready,
    output logic [7:0]            drop_count,
    output logic                  overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT_LOW
    } state_e;

    // Message fields. The top bit is reserved and deliberately ignored.
    logic [1:0]            rx_id;
    logic                  rx_vbit;
    logic                  rx_write;
    logic [ADDR_WIDTH-1:0] rx_addr;
    logic                  unused_reserved;

    assign rx_id           = bus_rx[1:0];
    assign rx_vbit         = bus_rx[2];
    assign rx_write        = bus_rx[3];
    assign rx_addr         = bus_rx[ADDR_WIDTH+3:4];
    assign unused_reserved = bus_rx[ADDR_WIDTH+4];

    state_e                state_q, state_d;
    logic                  ack_q, ack_d;
    logic [7:0]            drop_count_q, drop_count_d;
    logic                  overflow_q, overflow_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0] mem_q [DEPTH];

    logic                  push;
    logic                  pop;
    logic                  drop_inc;
    logic                  fifo_full;
    logic                  drop_msg;
    logic                  coalesce;
    logic [PTR_W-1:0]      last_ptr;

    assign fifo_full = (count_q == CNT_W'(DEPTH));
    assign inv_valid = (count_q != '0);
    assign pop       = inv_valid && inv_ready;
    assign last_ptr  = tail_q - PTR_W'(1);
    assign drop_msg  = !rx_vbit || !rx_write || (rx_id == ID);
    // A repeat of the newest queued address adds nothing, so it is folded in.
    assign coalesce  = inv_valid && (mem_q[last_ptr] == rx_addr);

    // Gating keeps the head output at zero while the unreset storage is empty.
    assign inv_addr   = inv_valid ? mem_q[head_q] : '0;
    assign bus_rx_ack = ack_q;
    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;

    // Receive FSM: classify in IDLE, ack for one cycle, then wait for valid to drop.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        state_d    = state_q;
        push       = 1'b0;
        drop_inc   = 1'b0;
        overflow_d = overflow_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus_rx_valid) begin
                    if (drop_msg) begin
                        drop_inc = 1'b1;
                        state_d  = ST_ACK;
                    end else if (coalesce) begin
                        state_d = ST_ACK;
                    end else if (!fifo_full) begin
                        push    = 1'b1;
                        state_d = ST_ACK;
                    end else begin
                        // Backpressure: no ack. A same-cycle pop frees no space until the next cycle.
                        overflow_d = 1'b1;
                    end
                end
            end
            ST_ACK:      state_d = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!bus_rx_valid) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Ack, saturating drop counter and FIFO pointer/count updates.
    always_comb begin
        ack_d        = (state_d == ST_ACK);
        drop_count_d = (drop_inc && (drop_count_q != 8'hFF)) ? drop_count_q + 8'd1 : drop_count_q;
        head_d       = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d       = push ? tail_q + PTR_W'(1) : tail_q;
        count_d      = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset clears any queued work and any ack in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ack_q        <= 1'b0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q      <= state_d;
            ack_q        <= ack_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clock) begin
        // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
        if (push) mem_q[tail_q] <= rx_addr;
    end

endmodule

// File: tb/tb_bus_snoop.sv
// Directed self-checking bench for bus_snoop.
module tb_bus_snoop;

    localparam int AW = 8;

    logic          clock;
    logic          reset_n;
    logic [AW+4:0] bus_rx;
    logic          bus_rx_valid;
    logic          bus_rx_ack;
    logic          inv_valid;
    logic [AW-1:0] inv_addr;
    logic          inv_ready;
    logic [7:0]    drop_count;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    bus_snoop #(.ADDR_WIDTH(AW), .ID(2'd2), .DEPTH(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus_rx       (bus_rx),
        .bus_rx_valid (bus_rx_valid),
        .bus_rx_ack   (bus_rx_ack),
        .inv_valid    (inv_valid),
        .inv_addr     (inv_addr),
        .inv_ready    (inv_ready),
        .drop_count   (drop_count),
        .overflow     (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW+4:0] msg(input logic [1:0] id, input logic wr, input logic [AW-1:0] a);
        return {1'b0, a, wr, 1'b1, id};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive a message until acked (bounded), then release and return to IDLE.
    task automatic send(input logic [AW+4:0] m, output bit acked);
        bus_rx       = m;
        bus_rx_valid = 1'b1;
        acked        = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_rx_ack) begin
                acked = 1'b1;
                break;
            end
        end
        bus_rx_valid = 1'b0;
        tick();
        tick();
    endtask

    // Check the FIFO head against an expected address, then pop it.
    task automatic drain(input string tag, input logic [AW-1:0] a);
        check({tag, "_valid"}, 32'(inv_valid), 32'd1);
        check({tag, "_addr"}, 32'(inv_addr), 32'(a));
        inv_ready = 1'b1;
        tick();
        inv_ready = 1'b0;
    endtask

    initial begin
        bit  acked;
        bit  any_ack;
        int  ack_cnt;
        int  first_ack;

        reset_n      = 1'b0;
        bus_rx       = '0;
        bus_rx_valid = 1'b0;
        inv_ready    = 1'b0;
        #22;
        reset_n = 1'b1;
        tick();

        // Reset values.
        check("rst_ack",   32'(bus_rx_ack), 32'd0);
        check("rst_valid", 32'(inv_valid),  32'd0);
        check("rst_addr",  32'(inv_addr),   32'd0);
        check("rst_drop",  32'(drop_count), 32'd0);
        check("rst_ovf",   32'(overflow),   32'd0);

        // Write from ID 1 to 0x5A, valid held for 4 cycles: exactly one ack, in the cycle after capture.
        bus_rx       = msg(2'd1, 1'b1, 8'h5A);
        bus_rx_valid = 1'b1;
        ack_cnt      = 0;
        first_ack    = -1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus_rx_ack) begin
                ack_cnt++;
                if (first_ack < 0) first_ack = i;
            end
        end
        bus_rx_valid = 1'b0;
        tick();
        tick();
        check("t1_ack_count", 32'(ack_cnt), 32'd1);
        check("t1_ack_cycle", 32'(first_ack), 32'd0);
        drain("t1_head", 8'h5A);
        check("t1_single_entry", 32'(inv_valid), 32'd0);

        // Own-ID write and a read: both acked and dropped.
        send(msg(2'd2, 1'b1, 8'h33), acked);
        check("t2_own_ack", 32'(acked), 32'd1);
        send(msg(2'd1, 1'b0, 8'h44), acked);
        check("t2_read_ack", 32'(acked), 32'd1);
        check("t2_no_inv", 32'(inv_valid), 32'd0);
        check("t2_drops", 32'(drop_count), 32'd2);

        // Fill the FIFO, then a fifth write is backpressured.
        for (int a = 1; a <= 4; a++) begin
            send(msg(2'd0, 1'b1, AW'(a)), acked);
            check($sformatf("t3_ack_%0d", a), 32'(acked), 32'd1);
        end
        bus_rx       = msg(2'd0, 1'b1, 8'h05);
        bus_rx_valid = 1'b1;
        any_ack      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus_rx_ack) any_ack = 1'b1;
        end
        check("t3_fifth_no_ack", 32'(any_ack), 32'd0);
        check("t3_overflow", 32'(overflow), 32'd1);
        inv_ready = 1'b1;
        tick();
        inv_ready = 1'b0;
        check("t3_no_ack_on_pop", 32'(bus_rx_ack), 32'd0);
        tick();
        check("t3_fifth_ack", 32'(bus_rx_ack), 32'd1);
        bus_rx_valid = 1'b0;
        tick();
        tick();
        drain("t3_q0", 8'h02);
        drain("t3_q1", 8'h03);
        drain("t3_q2", 8'h04);
        drain("t3_q3", 8'h05);
        check("t3_empty", 32'(inv_valid), 32'd0);

        // Coalescing of a repeated write to the newest entry.
        send(msg(2'd1, 1'b1, 8'h10), acked);
        check("t4_ack0", 32'(acked), 32'd1);
        send(msg(2'd1, 1'b1, 8'h10), acked);
        check("t4_ack1", 32'(acked), 32'd1);
        send(msg(2'd1, 1'b1, 8'h11), acked);
        check("t4_ack2", 32'(acked), 32'd1);
        check("t4_drops", 32'(drop_count), 32'd2);
        drain("t4_q0", 8'h10);
        drain("t4_q1", 8'h11);
        check("t4_empty", 32'(inv_valid), 32'd0);

        // Push and pop in the same cycle with one entry queued.
        send(msg(2'd1, 1'b1, 8'h20), acked);
        check("t5_first_ack", 32'(acked), 32'd1);
        bus_rx       = msg(2'd3, 1'b1, 8'h21);
        bus_rx_valid = 1'b1;
        inv_ready    = 1'b1;
        tick();
        inv_ready = 1'b0;
        check("t5_ack", 32'(bus_rx_ack), 32'd1);
        bus_rx_valid = 1'b0;
        tick();
        tick();
        drain("t5_head", 8'h21);
        check("t5_count_one", 32'(inv_valid), 32'd0);

        // Reset asserted during ACK with three entries queued.
        send(msg(2'd1, 1'b1, 8'h31), acked);
        send(msg(2'd1, 1'b1, 8'h32), acked);
        send(msg(2'd1, 1'b1, 8'h33), acked);
        check("t6_third_ack", 32'(acked), 32'd1);
        bus_rx       = msg(2'd1, 1'b1, 8'h34);
        bus_rx_valid = 1'b1;
        tick();
        check("t6_in_ack", 32'(bus_rx_ack), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_ack",   32'(bus_rx_ack), 32'd0);
        check("t6_rst_valid", 32'(inv_valid),  32'd0);
        check("t6_rst_drop",  32'(drop_count), 32'd0);
        check("t6_rst_ovf",   32'(overflow),   32'd0);
        bus_rx_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        send(msg(2'd1, 1'b1, 8'h77), acked);
        check("t6_post_ack", 32'(acked), 32'd1);
        drain("t6_post_head", 8'h77);
        check("t6_post_empty", 32'(inv_valid), 32'd0);

        // Drop counter saturates at 255.
        for (int i = 0; i < 260; i++) send(msg(2'd1, 1'b0, AW'(i)), acked);
        check("t7_drop_sat", 32'(drop_count), 32'd255);
        check("t7_no_inv", 32'(inv_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
